// File: rtl/aes_batch_sequencer.sv
// Sequences an AES core for trace capture: optional key load, then N chained encryptions
// with a scope trigger per block. Define AES_SEQ_GAP_EN for a programmable inter-block gap.
module aes_batch_sequencer #(
    parameter int CNT_W = 16,
    parameter int GAP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             load_key,
    input  logic             abort,
    input  logic [CNT_W-1:0] count,
    input  logic [GAP_W-1:0] gap,
    input  logic [127:0]     key_in,
    input  logic [127:0]     pt_in,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] done_cnt,
    output logic [127:0]     ct_out,
    output logic             trig,
    output logic [127:0]     aes_kin,
    output logic [127:0]     aes_din,
    output logic             aes_krdy,
    output logic             aes_drdy,
    input  logic             aes_kvld,
    input  logic             aes_dvld,
    input  logic [127:0]     aes_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_KWAIT,
        S_DATA,
        S_DWAIT,
`ifdef AES_SEQ_GAP_EN
        S_GAP,
`endif
        S_FIN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             abort_q;
    logic             stop;
    logic             last;

`ifdef AES_SEQ_GAP_EN
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt;
`else
    logic             unused_gap;
    assign unused_gap = ^gap;
`endif

    assign cnt_nxt = done_cnt + CNT_W'(1);
    assign last    = (cnt_nxt == cnt_q);
    // abort is a level; remember it so a short pulse during KEY/DATA still ends the run
    assign stop    = abort | abort_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            done_cnt <= '0;
            ct_out   <= '0;
            trig     <= 1'b0;
            aes_kin  <= '0;
            aes_din  <= '0;
            aes_krdy <= 1'b0;
            aes_drdy <= 1'b0;
`ifdef AES_SEQ_GAP_EN
            gap_q    <= '0;
            gap_cnt  <= '0;
`endif
        end else begin
            aes_krdy <= 1'b0;
            aes_drdy <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            if (abort && state != S_IDLE && state != S_FIN)
                abort_q <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt_q    <= count;
                        aes_kin  <= key_in;
                        aes_din  <= pt_in;
                        done_cnt <= '0;
                        abort_q  <= 1'b0;
                        busy     <= 1'b1;
`ifdef AES_SEQ_GAP_EN
                        gap_q    <= gap;
`endif
                        if (count == '0) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else if (load_key) begin
                            state    <= S_KEY;
                            aes_krdy <= 1'b1;
                        end else begin
                            state    <= S_DATA;
                            aes_drdy <= 1'b1;
                            trig     <= 1'b1;
                        end
                    end
                end

                S_KEY: state <= S_KWAIT;

                S_KWAIT: begin
                    if (aes_kvld) begin
                        if (stop) begin
                            state   <= S_FIN;
                            aborted <= 1'b1;
                        end else begin
                            state    <= S_DATA;
                            aes_drdy <= 1'b1;
                            trig     <= 1'b1;
                        end
                    end
                end

                S_DATA: state <= S_DWAIT;

                S_DWAIT: begin
                    if (aes_dvld) begin
                        ct_out   <= aes_dout;
                        aes_din  <= aes_dout;
                        done_cnt <= cnt_nxt;
                        trig     <= 1'b0;
                        // a run that has just completed its last block reports done even if abort is up
                        if (last) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else if (stop) begin
                            state   <= S_FIN;
                            aborted <= 1'b1;
                        end else begin
`ifdef AES_SEQ_GAP_EN
                            if (gap_q != '0) begin
                                state   <= S_GAP;
                                gap_cnt <= gap_q;
                            end else begin
                                state    <= S_DATA;
                                aes_drdy <= 1'b1;
                                trig     <= 1'b1;
                            end
`else
                            state    <= S_DATA;
                            aes_drdy <= 1'b1;
                            trig     <= 1'b1;
`endif
                        end
                    end
                end

`ifdef AES_SEQ_GAP_EN
                S_GAP: begin
                    if (stop) begin
                        state   <= S_FIN;
                        aborted <= 1'b1;
                    end else if (gap_cnt == GAP_W'(1)) begin
                        state    <= S_DATA;
                        aes_drdy <= 1'b1;
                        trig     <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
`endif

                S_FIN: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    abort_q <= 1'b0;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_batch_sequencer.sv
// Bench for aes_batch_sequencer: a stand-in AES core with random latency plus a chained-block
// reference model; the core returns the FIPS-197 ciphertext for the FIPS key/plaintext pair.
module tb_aes_batch_sequencer;
    localparam int CNT_W = 16;
    localparam int GAP_W = 8;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_SEQ_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             load_key = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] count = '0;
    logic [GAP_W-1:0] gap = '0;
    logic [127:0]     key_in = '0;
    logic [127:0]     pt_in = '0;
    logic             busy, done, aborted, trig, aes_krdy, aes_drdy;
    logic [CNT_W-1:0] done_cnt;
    logic [127:0]     ct_out, aes_kin, aes_din;
    logic             aes_kvld = 1'b0;
    logic             aes_dvld = 1'b0;
    logic [127:0]     aes_dout = '0;

    aes_batch_sequencer #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk(clk), .rst(rst), .start(start), .load_key(load_key), .abort(abort),
        .count(count), .gap(gap), .key_in(key_in), .pt_in(pt_in),
        .busy(busy), .done(done), .aborted(aborted), .done_cnt(done_cnt), .ct_out(ct_out),
        .trig(trig), .aes_kin(aes_kin), .aes_din(aes_din), .aes_krdy(aes_krdy),
        .aes_drdy(aes_drdy), .aes_kvld(aes_kvld), .aes_dvld(aes_dvld), .aes_dout(aes_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs = 0;
    int chks = 0;

    function automatic logic [127:0] core_f(input logic [127:0] k, input logic [127:0] d);
        if (k == FIPS_KEY && d == FIPS_PT) return FIPS_CT;
        return ({d[94:0], d[127:95]} ^ k) + 128'h9e3779b97f4a7c15f39cc0605cedc834;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stand-in core and event monitor; the only writer of everything it records.
    logic [127:0] core_key = '0;
    logic [127:0] core_res = '0;
    int kt = 0, dt = 0, lat_force = 0;
    bit chk_trig = 1'b1;
    int krdy_n = 0, drdy_n = 0, done_n = 0, abrt_n = 0, busy_n = 0, trig_bad = 0;
    int krdy_cyc = 0, done_cyc = 0, abrt_cyc = 0;
    int drdy_cyc[$];
    int dvld_cyc[$];
    logic [127:0] din_q[$];

    initial begin
        bit inflight;
        forever begin
            @(negedge clk);
            inflight = (dt > 0);
            aes_kvld = 1'b0;
            aes_dvld = 1'b0;
            if (kt > 0) begin kt--; if (kt == 0) aes_kvld = 1'b1; end
            if (dt > 0) begin
                dt--;
                if (dt == 0) begin aes_dvld = 1'b1; aes_dout = core_res; dvld_cyc.push_back(cyc); end
            end
            if (aes_krdy) begin
                core_key = aes_kin; kt = $urandom_range(1, 4); krdy_n++; krdy_cyc = cyc;
            end
            if (aes_drdy) begin
                core_res = core_f(core_key, aes_din);
                dt = (lat_force > 0) ? lat_force : $urandom_range(1, 5);
                din_q.push_back(aes_din); drdy_cyc.push_back(cyc); drdy_n++;
            end
            if (done) begin done_n++; done_cyc = cyc; end
            if (aborted) begin abrt_n++; abrt_cyc = cyc; end
            if (busy) busy_n++;
            if (chk_trig && !rst && trig !== (aes_drdy || inflight)) trig_bad++;
        end
    end

    function automatic int q_drdy(input int i);
        return (i >= 0 && i < drdy_cyc.size()) ? drdy_cyc[i] : -1000;
    endfunction
    function automatic int q_dvld(input int i);
        return (i >= 0 && i < dvld_cyc.size()) ? dvld_cyc[i] : -1000;
    endfunction
    function automatic logic [127:0] q_din(input int i);
        return (i >= 0 && i < din_q.size()) ? din_q[i] : 'x;
    endfunction

    logic [127:0] mkey = '0;
    int start_cyc, b_krdy, b_drdy, b_done, b_abrt, b_busy, b_trig, b_dq, b_vq;

    task automatic do_start(input bit lk, input int n, input int g,
                            input logic [127:0] k, input logic [127:0] p);
        @(negedge clk);
        b_krdy = krdy_n; b_drdy = drdy_n; b_done = done_n; b_abrt = abrt_n;
        b_busy = busy_n; b_trig = trig_bad; b_dq = drdy_cyc.size(); b_vq = dvld_cyc.size();
        load_key = lk; count = CNT_W'(n); gap = GAP_W'(g); key_in = k; pt_in = p;
        start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        key_in = rnd128(); pt_in = rnd128(); count = CNT_W'($urandom); gap = GAP_W'($urandom);
    endtask

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!busy && kt == 0 && dt == 0) begin to = 1'b0; break; end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chks++; if ({busy, done, aborted, trig, aes_krdy, aes_drdy} !== 6'b0) begin
            errs++; $display("FAIL reset_flags: got %b want 000000", {busy, done, aborted, trig, aes_krdy, aes_drdy}); end
        chks++; if (done_cnt !== '0) begin errs++; $display("FAIL reset_done_cnt: got %0d want 0", done_cnt); end
        chks++; if (ct_out !== '0) begin errs++; $display("FAIL reset_ct_out: got %h want 0", ct_out); end
        chks++; if ({aes_kin, aes_din} !== '0) begin errs++; $display("FAIL reset_kin_din: got %h %h want 0", aes_kin, aes_din); end
        rst = 1'b0;
    endtask

    task automatic test_fips();
        bit to;
        mkey = FIPS_KEY;
        do_start(1'b1, 1, 0, FIPS_KEY, FIPS_PT);
        wait_idle(to);
        chks++; if (to) begin errs++; $display("FAIL fips_timeout: busy=%0b want 0", busy); end
        chks++; if (krdy_n - b_krdy !== 1) begin errs++; $display("FAIL fips_krdy_n: got %0d want 1", krdy_n - b_krdy); end
        chks++; if (krdy_cyc - start_cyc !== 1) begin errs++; $display("FAIL fips_krdy_lat: got %0d want 1", krdy_cyc - start_cyc); end
        chks++; if (drdy_n - b_drdy !== 1) begin errs++; $display("FAIL fips_drdy_n: got %0d want 1", drdy_n - b_drdy); end
        chks++; if (ct_out !== FIPS_CT) begin errs++; $display("FAIL fips_ct: got %h want %h", ct_out, FIPS_CT); end
        chks++; if (done_cnt !== CNT_W'(1)) begin errs++; $display("FAIL fips_done_cnt: got %0d want 1", done_cnt); end
        chks++; if (done_n - b_done !== 1 || abrt_n - b_abrt !== 0) begin
            errs++; $display("FAIL fips_pulses: done %0d aborted %0d want 1 0", done_n - b_done, abrt_n - b_abrt); end
        chks++; if (done_cyc - q_dvld(b_vq) !== 1) begin errs++; $display("FAIL fips_done_lat: got %0d want 1", done_cyc - q_dvld(b_vq)); end
        chks++; if (busy_n - b_busy !== done_cyc - start_cyc) begin
            errs++; $display("FAIL fips_busy_len: got %0d want %0d", busy_n - b_busy, done_cyc - start_cyc); end
        chks++; if (trig_bad - b_trig !== 0) begin errs++; $display("FAIL fips_trig: got %0d bad cycles want 0", trig_bad - b_trig); end
    endtask

    task automatic test_chain();
        logic [127:0] p, d;
        bit to;
        p = rnd128(); d = p;
        do_start(1'b0, 3, 0, rnd128(), p);
        @(negedge clk);
        start = 1'b1; load_key = 1'b1; count = CNT_W'(7);
        @(negedge clk);
        start = 1'b0;
        wait_idle(to);
        chks++; if (to) begin errs++; $display("FAIL chain_timeout: busy=%0b want 0", busy); end
        chks++; if (drdy_n - b_drdy !== 3 || krdy_n - b_krdy !== 0) begin
            errs++; $display("FAIL chain_pulses: drdy %0d krdy %0d want 3 0", drdy_n - b_drdy, krdy_n - b_krdy); end
        chks++; if (q_drdy(b_dq) - start_cyc !== 1) begin errs++; $display("FAIL chain_first_lat: got %0d want 1", q_drdy(b_dq) - start_cyc); end
        for (int i = 0; i < 3; i++) begin
            chks++; if (q_din(b_dq + i) !== d) begin errs++; $display("FAIL chain_din%0d: got %h want %h", i, q_din(b_dq + i), d); end
            if (i > 0) begin
                chks++; if (q_drdy(b_dq + i) - q_dvld(b_vq + i - 1) !== 1) begin
                    errs++; $display("FAIL chain_lat%0d: got %0d want 1", i, q_drdy(b_dq + i) - q_dvld(b_vq + i - 1)); end
            end
            d = core_f(mkey, d);
        end
        chks++; if (done_cnt !== CNT_W'(3)) begin errs++; $display("FAIL chain_done_cnt: got %0d want 3", done_cnt); end
        chks++; if (ct_out !== d) begin errs++; $display("FAIL chain_ct: got %h want %h", ct_out, d); end
        chks++; if (trig_bad - b_trig !== 0) begin errs++; $display("FAIL chain_trig: got %0d bad cycles want 0", trig_bad - b_trig); end
    endtask

    task automatic test_zero();
        bit to;
        do_start(1'b1, 0, 0, rnd128(), rnd128());
        wait_idle(to);
        chks++; if (to) begin errs++; $display("FAIL zero_timeout: busy=%0b want 0", busy); end
        chks++; if (done_n - b_done !== 1 || done_cyc - start_cyc !== 1) begin
            errs++; $display("FAIL zero_done: pulses %0d latency %0d want 1 1", done_n - b_done, done_cyc - start_cyc); end
        chks++; if (busy_n - b_busy !== 1) begin errs++; $display("FAIL zero_busy_len: got %0d want 1", busy_n - b_busy); end
        chks++; if (krdy_n - b_krdy !== 0 || drdy_n - b_drdy !== 0) begin
            errs++; $display("FAIL zero_core: krdy %0d drdy %0d want 0 0", krdy_n - b_krdy, drdy_n - b_drdy); end
        chks++; if (done_cnt !== '0) begin errs++; $display("FAIL zero_done_cnt: got %0d want 0", done_cnt); end
    endtask

    task automatic test_abort();
        logic [127:0] p, d;
        bit to;
        p = rnd128();
        d = core_f(mkey, core_f(mkey, p));
        lat_force = 6;
        do_start(1'b0, 5, 0, rnd128(), p);
        for (int n = 0; n < 200 && drdy_n - b_drdy < 2; n++) @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        wait_idle(to);
        abort = 1'b0;
        lat_force = 0;
        chks++; if (to) begin errs++; $display("FAIL abort_timeout: busy=%0b want 0", busy); end
        chks++; if (abrt_n - b_abrt !== 1 || done_n - b_done !== 0) begin
            errs++; $display("FAIL abort_pulses: aborted %0d done %0d want 1 0", abrt_n - b_abrt, done_n - b_done); end
        chks++; if (abrt_cyc - q_dvld(b_vq + 1) !== 1) begin errs++; $display("FAIL abort_lat: got %0d want 1", abrt_cyc - q_dvld(b_vq + 1)); end
        chks++; if (done_cnt !== CNT_W'(2)) begin errs++; $display("FAIL abort_done_cnt: got %0d want 2", done_cnt); end
        chks++; if (drdy_n - b_drdy !== 2) begin errs++; $display("FAIL abort_drdy_n: got %0d want 2", drdy_n - b_drdy); end
        chks++; if (ct_out !== d) begin errs++; $display("FAIL abort_ct: got %h want %h", ct_out, d); end
    endtask

    task automatic test_gap();
        logic [127:0] k, p;
        int want;
        bit to;
        k = rnd128(); p = rnd128(); mkey = k;
        want = GAP_EN ? 11 : 1;
        do_start(1'b1, 2, 10, k, p);
        wait_idle(to);
        chks++; if (to) begin errs++; $display("FAIL gap_timeout: busy=%0b want 0", busy); end
        chks++; if (q_drdy(b_dq + 1) - q_dvld(b_vq) !== want) begin
            errs++; $display("FAIL gap_lat: got %0d want %0d", q_drdy(b_dq + 1) - q_dvld(b_vq), want); end
        chks++; if (trig_bad - b_trig !== 0) begin errs++; $display("FAIL gap_trig: got %0d bad cycles want 0", trig_bad - b_trig); end
        chks++; if (done_cnt !== CNT_W'(2)) begin errs++; $display("FAIL gap_done_cnt: got %0d want 2", done_cnt); end
        chks++; if (ct_out !== core_f(k, core_f(k, p))) begin
            errs++; $display("FAIL gap_ct: got %h want %h", ct_out, core_f(k, core_f(k, p))); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] p;
        bit to;
        lat_force = 10;
        do_start(1'b0, 4, 0, rnd128(), rnd128());
        for (int n = 0; n < 200 && drdy_n - b_drdy < 1; n++) @(negedge clk);
        @(negedge clk);
        chk_trig = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chks++; if ({busy, done, aborted, trig, aes_krdy, aes_drdy} !== 6'b0) begin
            errs++; $display("FAIL rstmid_flags: got %b want 000000", {busy, done, aborted, trig, aes_krdy, aes_drdy}); end
        chks++; if (done_cnt !== '0 || ct_out !== '0) begin
            errs++; $display("FAIL rstmid_regs: done_cnt %0d ct %h want 0 0", done_cnt, ct_out); end
        chks++; if ({aes_kin, aes_din} !== '0) begin errs++; $display("FAIL rstmid_kin_din: got %h %h want 0", aes_kin, aes_din); end
        for (int n = 0; n < 50 && dt > 0; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        chks++; if (busy !== 1'b0 || done_cnt !== '0 || ct_out !== '0 || done_n - b_done !== 0) begin
            errs++; $display("FAIL rstmid_late_dvld: busy %0b done_cnt %0d ct %h done %0d want 0", busy, done_cnt, ct_out, done_n - b_done); end
        lat_force = 0;
        chk_trig = 1'b1;
        p = rnd128();
        do_start(1'b0, 2, 0, rnd128(), p);
        wait_idle(to);
        chks++; if (to) begin errs++; $display("FAIL rstmid_timeout: busy=%0b want 0", busy); end
        chks++; if (done_cnt !== CNT_W'(2) || done_n - b_done !== 1) begin
            errs++; $display("FAIL rstmid_rerun: done_cnt %0d done %0d want 2 1", done_cnt, done_n - b_done); end
        chks++; if (ct_out !== core_f(mkey, core_f(mkey, p))) begin
            errs++; $display("FAIL rstmid_ct: got %h want %h", ct_out, core_f(mkey, core_f(mkey, p))); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [127:0] k, p, d;
            int n, g, bad_din, bad_lat;
            bit lk, to;
            lk = 1'($urandom_range(0, 1)); n = $urandom_range(1, 6); g = $urandom_range(0, 3);
            k = rnd128(); p = rnd128();
            if (lk) mkey = k;
            do_start(lk, n, g, k, p);
            wait_idle(to);
            d = p; bad_din = 0; bad_lat = 0;
            for (int i = 0; i < n; i++) begin
                if (q_din(b_dq + i) !== d) bad_din++;
                if (i > 0 && q_drdy(b_dq + i) - q_dvld(b_vq + i - 1) !== (GAP_EN ? 1 + g : 1)) bad_lat++;
                d = core_f(mkey, d);
            end
            chks++; if (to) begin errs++; $display("FAIL rnd%0d_timeout: busy=%0b want 0", it, busy); end
            chks++; if (done_cnt !== CNT_W'(n) || drdy_n - b_drdy !== n) begin
                errs++; $display("FAIL rnd%0d_count: done_cnt %0d drdy %0d want %0d", it, done_cnt, drdy_n - b_drdy, n); end
            chks++; if (ct_out !== d) begin errs++; $display("FAIL rnd%0d_ct: got %h want %h", it, ct_out, d); end
            chks++; if (bad_din !== 0) begin errs++; $display("FAIL rnd%0d_din: got %0d wrong blocks want 0", it, bad_din); end
            chks++; if (bad_lat !== 0 || trig_bad - b_trig !== 0) begin
                errs++; $display("FAIL rnd%0d_timing: lat %0d trig %0d want 0 0", it, bad_lat, trig_bad - b_trig); end
        end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_chain();
        test_zero();
        test_abort();
        test_gap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
